afifo_rd_driver: RTL and testbench

- Synthesizable read-side traffic engine for the async FIFO read port, in the rclk domain.
- Drives rinc against rempty in programmable bursts with idle gaps, and captures rdata on every accepted pop.
- Checks popped data against an incrementing expected sequence and keeps read, error and underflow counters.
- Used as the consumer end in FIFO stress benches and FPGA soak builds; the read-port monitor observes the same pins.

---
 rtl/afifo_rd_driver_if.sv | 11 +
 rtl/afifo_rd_driver.sv | 127 ++++++++++++
 tb/tb_afifo_rd_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_driver_if.sv
// Async FIFO read-port bundle: the traffic engine (master) pops, the FIFO (slave) supplies data and empty.
interface afifo_rd_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rinc;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output rinc, input rempty, input rdata);
  modport slave  (input rinc, output rempty, output rdata);
endinterface

// File: rtl/afifo_rd_driver.sv
// Read-side traffic engine for the async FIFO: bursty pops, data checking against an
// incrementing sequence, and saturating read/error/underflow statistics.
module afifo_rd_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   num_reads,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  input  logic [DATA_WIDTH-1:0]  exp_seed,
  input  logic                   force_underflow,
  afifo_rd_driver_if.master      fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_valid,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [CNT_WIDTH-1:0]   rd_count,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic [CNT_WIDTH-1:0]   uflow_count
);

  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

  state_t                 state, next_state;
  logic [CNT_WIDTH-1:0]   reads_left;
  logic [BURST_WIDTH-1:0] burst_left;
  logic [BURST_WIDTH-1:0] burst_len_l;
  logic [GAP_WIDTH-1:0]   gap_left;
  logic [GAP_WIDTH-1:0]   gap_cycles_l;
  logic [DATA_WIDTH-1:0]  exp_data;
  logic                   force_underflow_l;
  logic                   pop;
  logic                   uflow;
  logic                   burst_end;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // rinc is gated by rrst so the FIFO never sees a pop in a reset cycle
  assign fifo.rinc = (state == BURST) && (!fifo.rempty || force_underflow_l) && !rrst;
  assign pop       = fifo.rinc && !fifo.rempty;
  assign uflow     = fifo.rinc && fifo.rempty;
  assign burst_end = (burst_len_l != '0) && (burst_left == BURST_WIDTH'(1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge rclk) begin
    if (rrst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = (num_reads == '0) ? DONE : BURST;
      BURST: begin
        if (pop) begin
          if (reads_left == CNT_WIDTH'(1))            next_state = DONE;
          else if (burst_end && gap_cycles_l != '0)   next_state = GAP;
        end
      end
      GAP:   if (gap_left <= GAP_WIDTH'(1)) next_state = BURST;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_valid          <= 1'b0;
      rd_data           <= '0;
      rd_count          <= '0;
      err_count         <= '0;
      uflow_count       <= '0;
      reads_left        <= '0;
      burst_left        <= '0;
      burst_len_l       <= '0;
      gap_left          <= '0;
      gap_cycles_l      <= '0;
      exp_data          <= '0;
      force_underflow_l <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            burst_len_l       <= burst_len;
            gap_cycles_l      <= gap_cycles;
            force_underflow_l <= force_underflow;
            reads_left        <= num_reads;
            burst_left        <= burst_len;
            exp_data          <= exp_seed;
            rd_count          <= '0;
            err_count         <= '0;
            uflow_count       <= '0;
          end
        end
        BURST: begin
          if (pop) begin
            rd_data    <= fifo.rdata;
            rd_valid   <= 1'b1;
            exp_data   <= exp_data + DATA_WIDTH'(1);
            rd_count   <= sat_inc(rd_count);
            reads_left <= reads_left - CNT_WIDTH'(1);
            gap_left   <= gap_cycles_l;
            if (fifo.rdata != exp_data) err_count <= sat_inc(err_count);
            // Burst counter reloads at the end of each burst; unbounded mode leaves it alone
            if (burst_len_l != '0) begin
              if (burst_end) burst_left <= burst_len_l;
              else           burst_left <= burst_left - BURST_WIDTH'(1);
            end
          end
          if (uflow) uflow_count <= sat_inc(uflow_count);
        end
        GAP: gap_left <= gap_left - GAP_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_rd_driver.sv
// Directed bench for afifo_rd_driver: a behavioural FIFO feeds the read port, a vector
// table covers drain/burst/data-check runs, and hand sequences cover stall, underflow and reset.
module tb_afifo_rd_driver;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int BW = 8;
  localparam int GW = 8;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          start;
  logic [CW-1:0] num_reads;
  logic [BW-1:0] burst_len;
  logic [GW-1:0] gap_cycles;
  logic [DW-1:0] exp_seed;
  logic          force_underflow;
  logic          busy, done, rd_valid;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] rd_count, err_count, uflow_count;

  int total = 0;
  int bad   = 0;

  always #5 rclk = ~rclk;

  afifo_rd_driver_if #(.DATA_WIDTH(DW)) fif ();

  afifo_rd_driver #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_WIDTH(BW), .GAP_WIDTH(GW)
  ) dut (
    .rclk(rclk), .rrst(rrst), .start(start), .num_reads(num_reads),
    .burst_len(burst_len), .gap_cycles(gap_cycles), .exp_seed(exp_seed),
    .force_underflow(force_underflow), .fifo(fif), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_count(rd_count),
    .err_count(err_count), .uflow_count(uflow_count)
  );

  // Behavioural FIFO: writes come from the test sequence, pops from the DUT's rinc
  logic [DW-1:0] mem [256];
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic          flush;
  logic [DW-1:0] exp_q [$];

  assign fif.rempty = (wr_ptr == rd_ptr);
  assign fif.rdata  = mem[rd_ptr];

  always @(posedge rclk) begin
    if (flush)                         rd_ptr <= wr_ptr;
    else if (fif.rinc && !fif.rempty)  rd_ptr <= rd_ptr + 8'd1;
  end

  typedef struct {
    logic [CW-1:0] n;
    logic [BW-1:0] blen;
    logic [GW-1:0] gap;
    logic [DW-1:0] seed;
    logic [DW-1:0] fill_start;
    int            fill_n;
    int            bad_idx;
    logic [DW-1:0] bad_val;
    logic [CW-1:0] e_rd;
    logic [CW-1:0] e_err;
    int            e_first_err;
    logic [31:0]   e_mask;
    int            e_done;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_data(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(v);
  endtask

  task automatic flush_fifo();
    @(negedge rclk);
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic launch(input logic [CW-1:0] n, input logic [BW-1:0] b, input logic [GW-1:0] g,
                        input logic [DW-1:0] s, input logic fu);
    @(negedge rclk);
    num_reads       = n;
    burst_len       = b;
    gap_cycles      = g;
    exp_seed        = s;
    force_underflow = fu;
    start           = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge rclk);
      start = 1'b0;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int          cyc, done_at, pops, first_err;
    logic [31:0] mask;
    flush_fifo();
    for (int i = 0; i < v.fill_n; i++)
      push_data((i == v.bad_idx) ? v.bad_val : v.fill_start + DW'(i));
    launch(v.n, v.blen, v.gap, v.seed, 1'b0);
    cyc = 0; done_at = 0; pops = 0; first_err = 0; mask = '0;
    while (done_at == 0 && cyc < 200) begin
      @(negedge rclk);
      start = 1'b0;
      cyc++;
      if (fif.rinc && cyc <= 32) mask[cyc-1] = 1'b1;
      if (rd_valid) begin
        pops++;
        if (exp_q.size() == 0) checkOutput($sformatf("v%0d_extra_pop", idx), 32'd1, 32'd0);
        else                   checkOutput($sformatf("v%0d_rd_data%0d", idx, pops), rd_data, exp_q.pop_front());
        if (err_count != '0 && first_err == 0) first_err = pops;
      end
      if (done) done_at = cyc;
    end
    checkOutput($sformatf("v%0d_done_cycle", idx), done_at, v.e_done);
    checkOutput($sformatf("v%0d_rinc_mask", idx), mask, v.e_mask);
    checkOutput($sformatf("v%0d_rd_count", idx), rd_count, v.e_rd);
    checkOutput($sformatf("v%0d_err_count", idx), err_count, v.e_err);
    checkOutput($sformatf("v%0d_first_err_pop", idx), first_err, v.e_first_err);
    checkOutput($sformatf("v%0d_uflow_count", idx), uflow_count, 0);
    @(negedge rclk);
    checkOutput($sformatf("v%0d_idle_after", idx), {busy, done}, 2'b00);
  endtask

  initial begin
    int cyc, n_rinc, n_done;
    // n, blen, gap, seed, fill_start, fill_n, bad_idx, bad_val, e_rd, e_err, e_first_err, e_mask, e_done
    vecs[0] = '{16'd0,  8'd0, 8'd0, 8'h00, 8'h00, 0,  -1, 8'h00, 16'd0,  16'd0, 0, 32'h0000_0000, 1};
    vecs[1] = '{16'd16, 8'd0, 8'd0, 8'h10, 8'h10, 16, -1, 8'h00, 16'd16, 16'd0, 0, 32'h0000_FFFF, 17};
    vecs[2] = '{16'd10, 8'd4, 8'd3, 8'h00, 8'h00, 10, -1, 8'h00, 16'd10, 16'd0, 0, 32'h0000_C78F, 17};
    vecs[3] = '{16'd4,  8'd0, 8'd0, 8'hFE, 8'hFE, 4,  3,  8'h05, 16'd4,  16'd1, 4, 32'h0000_000F, 5};
    vecs[4] = '{16'd3,  8'd0, 8'd0, 8'h20, 8'h21, 3,  -1, 8'h00, 16'd3,  16'd3, 1, 32'h0000_0007, 4};
    vecs[5] = '{16'd7,  8'd3, 8'd0, 8'h40, 8'h40, 7,  -1, 8'h00, 16'd7,  16'd0, 0, 32'h0000_007F, 8};
    vecs[6] = '{16'd3,  8'd1, 8'd1, 8'h50, 8'h50, 3,  -1, 8'h00, 16'd3,  16'd0, 0, 32'h0000_0015, 6};

    rrst = 1'b1; start = 1'b0; flush = 1'b1; wr_ptr = 8'd0;
    num_reads = '0; burst_len = '0; gap_cycles = '0; exp_seed = '0; force_underflow = 1'b0;
    repeat (3) @(negedge rclk);
    checkOutput("reset_rinc", fif.rinc, 1'b0);
    checkOutput("reset_flags", {busy, done, rd_valid}, 3'b000);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_counts", {rd_count, err_count, uflow_count}, 0);
    rrst = 1'b0; flush = 1'b0;

    // Empty stall: three entries, then the FIFO runs dry mid-run
    flush_fifo();
    for (int i = 0; i < 3; i++) push_data(8'h30 + 8'(i));
    launch(16'd6, 8'd0, 8'd0, 8'h30, 1'b0);
    repeat (4) begin @(negedge rclk); start = 1'b0; end
    n_rinc = 0;
    for (int i = 0; i < 20; i++) begin
      if (fif.rinc) n_rinc++;
      @(negedge rclk);
    end
    checkOutput("stall_rinc_cycles", n_rinc, 0);
    checkOutput("stall_rd_count", rd_count, 3);
    checkOutput("stall_uflow", uflow_count, 0);
    checkOutput("stall_busy", busy, 1'b1);
    for (int i = 3; i < 6; i++) push_data(8'h30 + 8'(i));
    #1;
    checkOutput("stall_resume_rinc", fif.rinc, 1'b1);
    wait_done(cyc);
    checkOutput("stall_done_seen", cyc != 0, 1'b1);
    checkOutput("stall_final_rd", rd_count, 6);
    checkOutput("stall_final_err", err_count, 0);

    // Forced underflow: five pops against an empty FIFO, then two writes
    flush_fifo();
    launch(16'd2, 8'd0, 8'd0, 8'h60, 1'b1);
    n_rinc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      start = 1'b0;
      if (fif.rinc) n_rinc++;
    end
    checkOutput("uf_rinc_while_empty", n_rinc, 5);
    @(negedge rclk);
    push_data(8'h60);
    push_data(8'h61);
    wait_done(cyc);
    checkOutput("uf_done_seen", cyc != 0, 1'b1);
    checkOutput("uf_uflow_count", uflow_count, 5);
    checkOutput("uf_rd_count", rd_count, 2);
    checkOutput("uf_err_count", err_count, 0);
    force_underflow = 1'b0;

    // Reset during the third pop of the first burst
    flush_fifo();
    for (int i = 0; i < 20; i++) push_data(8'(i));
    launch(16'd10, 8'd4, 8'd3, 8'h00, 1'b0);
    repeat (3) begin @(negedge rclk); start = 1'b0; end
    checkOutput("rst_pre_rd_count", rd_count, 2);
    rrst = 1'b1;
    #1;
    checkOutput("rst_rinc_gated", fif.rinc, 1'b0);
    @(negedge rclk);
    rrst = 1'b0;
    checkOutput("rst_flags", {busy, done, rd_valid}, 3'b000);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_counts", {rd_count, err_count, uflow_count}, 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (done) n_done++;
    end
    checkOutput("rst_no_done", n_done, 0);

    for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
